// File: rtl/issue_pkg.sv
// Shared definitions for the operand-fetch/issue stage: instruction field
// layout, opcode constants and the register index type.
package issue_pkg;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 9;
  localparam int RA_MSB  = 8;
  localparam int RA_LSB  = 6;
  localparam int RB_MSB  = 5;
  localparam int RB_LSB  = 3;
  localparam int UPD_BIT = 0;

  localparam logic [3:0] OP_ADD = 4'b0110;
  localparam logic [3:0] OP_SUB = 4'b0111;
  localparam logic [3:0] OP_AND = 4'b1000;

  typedef logic [2:0] reg_idx_t;

  typedef struct packed {
    logic [3:0] opc;
    reg_idx_t   rd;
    reg_idx_t   ra;
    reg_idx_t   rb;
    logic       upd;
  } instr_t;

  // Bits [2:1] of the word carry nothing and are dropped here.
  function automatic instr_t decode(input logic [15:0] w);
    instr_t d;
    d.opc = w[OPC_MSB:OPC_LSB];
    d.rd  = w[RD_MSB:RD_LSB];
    d.ra  = w[RA_MSB:RA_LSB];
    d.rb  = w[RB_MSB:RB_LSB];
    d.upd = w[UPD_BIT];
    return d;
  endfunction

endpackage

// File: rtl/issue_regbank.sv
// Register bank for the issue stage: two combinational read ports, one write
// port, R0 hardwired to zero.
module issue_regbank #(
  parameter int NREGS = 8,
  parameter int DW    = 8,
  parameter int IW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [IW-1:0] raddr_a,
  output logic [DW-1:0] rdata_a,
  input  logic [IW-1:0] raddr_b,
  output logic [DW-1:0] rdata_b
);

  logic [NREGS-1:0][DW-1:0] regs_q, regs_d;

  always_comb begin
    regs_d = regs_q;
    if (we && waddr != '0) regs_d[waddr] = wdata;
    regs_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) regs_q <= '0;
    else       regs_q <= regs_d;
  end

  assign rdata_a = (raddr_a == '0) ? '0 : regs_q[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : regs_q[raddr_b];

endmodule

// File: rtl/operand_issue_stage.sv
// Operand fetch and issue into the ALU with a busy-bit scoreboard.
// Optional macro ISSUE_FWD_EN: bypass same-cycle writeback into operand read.
module operand_issue_stage
  import issue_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [15:0]   in_instr,
  output logic          alu_valid,
  input  logic          alu_ready,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [3:0]    alu_opcode,
  output logic [2:0]    alu_rd,
  output logic          alu_update,
  input  logic          wb_valid,
  input  logic [2:0]    wb_rd,
  input  logic [DW-1:0] wb_data
);

`ifdef ISSUE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  instr_t          ins;
  logic            wb_fire, blocked, accept;
  logic [NREGS-1:0] busy_q, busy_d, busy_eff;
  logic [DW-1:0]   rdata_a, rdata_b, op_a, op_b;

  logic            vld_q, vld_d, upd_q, upd_d;
  logic [DW-1:0]   a_q, a_d, b_q, b_d;
  logic [3:0]      opc_q, opc_d;
  reg_idx_t        rd_q, rd_d;

  assign ins     = decode(in_instr);
  assign wb_fire = wb_valid && !reset;

  issue_regbank #(.NREGS(NREGS), .DW(DW)) u_bank (
    .clk     (clk),
    .reset   (reset),
    .we      (wb_fire),
    .waddr   (wb_rd),
    .wdata   (wb_data),
    .raddr_a (ins.ra),
    .rdata_a (rdata_a),
    .raddr_b (ins.rb),
    .rdata_b (rdata_b)
  );

  always_comb begin
    // With forwarding, a register retired this cycle no longer blocks.
    busy_eff = busy_q;
    if (FWD && wb_fire) busy_eff[wb_rd] = 1'b0;
    blocked  = busy_eff[ins.ra] | busy_eff[ins.rb] | busy_eff[ins.rd];
    in_ready = !reset && !blocked && (!vld_q || alu_ready);
    accept   = in_valid && in_ready;

    op_a = rdata_a;
    op_b = rdata_b;
    if (FWD && wb_fire && wb_rd == ins.ra && ins.ra != '0) op_a = wb_data;
    if (FWD && wb_fire && wb_rd == ins.rb && ins.rb != '0) op_b = wb_data;

    // Clear before set so a same-cycle issue to wb_rd leaves it busy.
    busy_d = busy_q;
    if (wb_fire) busy_d[wb_rd] = 1'b0;
    if (accept && ins.rd != '0) busy_d[ins.rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    vld_d = vld_q;
    a_d   = a_q;
    b_d   = b_q;
    opc_d = opc_q;
    rd_d  = rd_q;
    upd_d = upd_q;
    if (accept) begin
      vld_d = 1'b1;
      a_d   = op_a;
      b_d   = op_b;
      opc_d = ins.opc;
      rd_d  = ins.rd;
      upd_d = ins.upd;
    end else if (alu_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
      vld_q  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      opc_q  <= '0;
      rd_q   <= '0;
      upd_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      vld_q  <= vld_d;
      a_q    <= a_d;
      b_q    <= b_d;
      opc_q  <= opc_d;
      rd_q   <= rd_d;
      upd_q  <= upd_d;
    end
  end

  assign alu_valid  = vld_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_opcode = opc_q;
  assign alu_rd     = rd_q;
  assign alu_update = upd_q && vld_q;

endmodule

// File: tb/tb_operand_issue_stage.sv
// Directed bench for operand_issue_stage; honours ISSUE_FWD_EN for the
// forwarding-dependent timing expectations.
module tb_operand_issue_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [15:0] in_instr;
  logic        alu_valid, alu_ready, alu_update;
  logic [7:0]  alu_a, alu_b;
  logic [3:0]  alu_opcode;
  logic [2:0]  alu_rd;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic [7:0]  wb_data;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  operand_issue_stage dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_rd     (alu_rd),
    .alu_update (alu_update),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data)
  );

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                     input logic [2:0] ra, input logic [2:0] rb,
                                     input logic upd);
    return {op, rd, ra, rb, 2'b00, upd};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change at negedge; #1 later in_ready is settled for this cycle.
  task automatic drive_nedge();
    @(negedge clk);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] opc, input logic [2:0] rd, input logic upd);
    chk({tag, ".valid"},  {31'd0, alu_valid}, 32'd1);
    chk({tag, ".a"},      {24'd0, alu_a}, {24'd0, a});
    chk({tag, ".b"},      {24'd0, alu_b}, {24'd0, b});
    chk({tag, ".opc"},    {28'd0, alu_opcode}, {28'd0, opc});
    chk({tag, ".rd"},     {29'd0, alu_rd}, {29'd0, rd});
    chk({tag, ".upd"},    {31'd0, alu_update}, {31'd0, upd});
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b1; in_instr = mk(4'b0110, 3'd1, 3'd2, 3'd3, 1'b1);
    alu_ready = 1'b1; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;

    // Reset with in_valid high
    for (int i = 0; i < 2; i++) begin
      drive_nedge(); #1;
      chk("rst.in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst.valid",    {31'd0, alu_valid}, 32'd0);
      chk("rst.outs",     {alu_a, alu_b, alu_opcode, 1'b0, alu_rd, 3'd0, alu_update}, 32'd0);
    end

    // Preload R1=5, R2=3
    drive_nedge(); reset = 1'b0; in_valid = 1'b0;
    wb_valid = 1'b1; wb_rd = 3'd1; wb_data = 8'd5;
    drive_nedge(); wb_rd = 3'd2; wb_data = 8'd3;
    drive_nedge(); wb_valid = 1'b0;
    in_valid = 1'b1; in_instr = mk(4'b0111, 3'd3, 3'd1, 3'd2, 1'b1);
    #1 chk("sub.in_ready", {31'd0, in_ready}, 32'd1);
    after_edge();
    chk_out("sub", 8'd5, 8'd3, 4'b0111, 3'd3, 1'b1);

    // Back-pressure: second word ADD rd=5 waits three cycles
    drive_nedge(); alu_ready = 1'b0; in_instr = mk(4'b0110, 3'd5, 3'd1, 3'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp.in_ready", {31'd0, in_ready}, 32'd0);
      after_edge();
      chk_out("bp.hold", 8'd5, 8'd3, 4'b0111, 3'd3, 1'b1);
      drive_nedge();
    end
    alu_ready = 1'b1;
    #1 chk("bp.release", {31'd0, in_ready}, 32'd1);
    after_edge();
    chk_out("add", 8'd5, 8'd3, 4'b0110, 3'd5, 1'b0);

    // RAW: ADD rd=4, then AND ra=4 rb=1, writeback R4=AA two cycles later
    drive_nedge(); in_instr = mk(4'b0110, 3'd4, 3'd1, 3'd2, 1'b0);
    after_edge();
    chk_out("add4", 8'd5, 8'd3, 4'b0110, 3'd4, 1'b0);
    drive_nedge(); in_instr = mk(4'b1000, 3'd6, 3'd4, 3'd1, 1'b0);
    #1 chk("raw.stall", {31'd0, in_ready}, 32'd0);
    drive_nedge(); wb_valid = 1'b1; wb_rd = 3'd4; wb_data = 8'hAA;
`ifdef ISSUE_FWD_EN
    #1 chk("raw.fwd_ready", {31'd0, in_ready}, 32'd1);
    after_edge();
    drive_nedge(); wb_valid = 1'b0;
`else
    #1 chk("raw.wb_cycle", {31'd0, in_ready}, 32'd0);
    drive_nedge(); wb_valid = 1'b0;
    #1 chk("raw.late_ready", {31'd0, in_ready}, 32'd1);
    after_edge();
    drive_nedge();
`endif
    chk_out("and", 8'hAA, 8'd5, 4'b1000, 3'd6, 1'b0);

    // R0: writeback FF to R0, then read R0 as both sources
    in_valid = 1'b0; wb_valid = 1'b1; wb_rd = 3'd0; wb_data = 8'hFF;
    drive_nedge(); wb_valid = 1'b0;
    in_valid = 1'b1; in_instr = mk(4'b0110, 3'd7, 3'd0, 3'd0, 1'b1);
    #1 chk("r0.ready", {31'd0, in_ready}, 32'd1);
    after_edge();
    chk_out("r0", 8'd0, 8'd0, 4'b0110, 3'd7, 1'b1);

    // WAW: SUB rd=5 while R5 still busy
    drive_nedge(); in_instr = mk(4'b0111, 3'd5, 3'd1, 3'd2, 1'b0);
    #1 chk("waw.stall0", {31'd0, in_ready}, 32'd0);
    drive_nedge();
    #1 chk("waw.stall1", {31'd0, in_ready}, 32'd0);
    drive_nedge(); wb_valid = 1'b1; wb_rd = 3'd5; wb_data = 8'h11;
`ifdef ISSUE_FWD_EN
    #1 chk("waw.fwd_ready", {31'd0, in_ready}, 32'd1);
    after_edge();
    drive_nedge(); wb_valid = 1'b0;
`else
    #1 chk("waw.wb_cycle", {31'd0, in_ready}, 32'd0);
    drive_nedge(); wb_valid = 1'b0;
    #1 chk("waw.late_ready", {31'd0, in_ready}, 32'd1);
    after_edge();
    drive_nedge();
`endif
    chk_out("waw", 8'd5, 8'd3, 4'b0111, 3'd5, 1'b0);

    // Hold the last word with busy[3] still set, then reset mid-flight
    in_valid = 1'b0; alu_ready = 1'b0;
    after_edge();
    chk("mid.valid_before", {31'd0, alu_valid}, 32'd1);
    drive_nedge(); reset = 1'b1; wb_valid = 1'b1; wb_rd = 3'd3; wb_data = 8'h77;
    #1 chk("mid.rst_ready", {31'd0, in_ready}, 32'd0);
    after_edge();
    chk("mid.valid_after", {31'd0, alu_valid}, 32'd0);
    chk("mid.upd_after",   {31'd0, alu_update}, 32'd0);
    drive_nedge(); reset = 1'b0; wb_valid = 1'b0; alu_ready = 1'b1;
    in_valid = 1'b1; in_instr = mk(4'b1000, 3'd1, 3'd3, 3'd3, 1'b1);
    #1 chk("mid.r3_ready", {31'd0, in_ready}, 32'd1);
    after_edge();
    chk_out("mid.r3", 8'd0, 8'd0, 4'b1000, 3'd1, 1'b1);

    drive_nedge(); in_valid = 1'b0;
    after_edge();
    chk("drain.valid", {31'd0, alu_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/operand_issue_stage.md
# operand_issue_stage

Operand-fetch and issue stage directly upstream of the ALU/FlagsRegister pair. It accepts decoded 16-bit instruction words and reads two source operands from an internal 8-entry register bank. Each instruction is presented to the ALU through a one-deep valid/ready output register, together with its opcode and flag-update strobe. It also receives ALU results on a writeback port, tracks pending destinations with a scoreboard, and stalls on hazards.

## Interface
- NREGS, 8, number of registers; register index width is log2(NREGS).
- DW, 8, data width; matches the ALU operand width.
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  instruction word valid.
- in_ready  out  1  stage accepts the word this cycle.
- in_instr  in  16  instruction word, fields as follows:
  - [15:12] opcode
  - [11:9] rd
  - [8:6] ra
  - [5:3] rb
  - [0] upd, flag-update request
  - [2:1] ignored.
- alu_valid  out  1  issued operation valid.
- alu_ready  in  1  ALU side consumes the operation.
- alu_a, alu_b  out  DW  operand values.
- alu_opcode  out  4  opcode, passed through.
- alu_rd  out  3  destination, passed through to the writeback path.
- alu_update  out  1  equals the registered upd bit AND alu_valid; drives FlagsRegister update.
- wb_valid  in  1  writeback valid.
- wb_rd  in  3  writeback destination.
- wb_data  in  DW  writeback value.

## Operation
**Register bank**
- R0 always reads 0, ignores writes, and is never busy.
- R1..R7 are DW-bit registers.

**Scoreboard**
- There is one busy bit per register.
- On issue, busy[rd] is set (when rd≠0).
- On wb_valid, busy[wb_rd] is cleared and the register is written.
- If an issue and a writeback hit the same register in the same cycle, the set wins.
- A writeback to a register that is not busy still writes the register; its busy bit stays 0.

**Hazards**
- An instruction is blocked when any of the following holds:
  - busy[ra] is set,
  - busy[rb] is set,
  - busy[rd] is set (WAW).
- A busy register is not treated as blocking when it is resolved by same-cycle forwarding (see Configuration).

**Acceptance rule**
- in_ready = !reset && !blocked && (!alu_valid || alu_ready).
- A word is accepted when in_valid && in_ready.

**Operand read**
- Operands are read in the acceptance cycle.
- If forwarding is enabled and wb_valid && wb_rd==ra (ra≠0), the operand is taken from wb_data; the same applies to rb.

**Output register**
- Loaded on acceptance.
- alu_valid is cleared when alu_ready is high and no new word is accepted.
- All outputs hold their values while alu_valid && !alu_ready.
- An opcode is issued regardless of whether the ALU implements it; opcode legality is decided downstream.

## Timing
- **Reset values:**
  - alu_valid=0, alu_a=0, alu_b=0, alu_opcode=0, alu_rd=0, alu_update=0
  - all busy bits 0, all registers 0
  - in_ready=0 while reset is high.
- **Issue latency:** a word accepted at edge N appears on the alu_* outputs from edge N onward, i.e. one cycle.
- **Throughput:** one issue per cycle when alu_ready=1 and there is no hazard.
- **Writeback:** a value written at edge N is readable from the bank in cycle N+1.
- **Reset mid-operation:** the in-flight ALU word and all busy bits are discarded; wb_valid is ignored while reset is high.

## Configuration
- ISSUE_FWD_EN defined:
  - The same-cycle writeback is bypassed into operand read.
  - A source or destination whose busy bit is cleared by the current writeback does not block.
- ISSUE_FWD_EN undefined:
  - No bypass.
  - A dependent instruction stalls until the edge after writeback and issues one cycle later than it would with forwarding.

## Structure
- Package issue_pkg holds:
  - instruction field positions (OPC_MSB/LSB, RD/RA/RB positions, UPD_BIT)
  - opcode constants OP_ADD=4'b0110, OP_SUB=4'b0111, OP_AND=4'b1000
  - the reg_idx_t typedef.
- One sub-module, issue_regbank: two combinational read ports, one write port, and R0 hardwired to zero.
- The scoreboard, handshake logic and output register live in the top module.

## Test plan
1. **Reset:** hold reset for 2 cycles with in_valid=1 -> in_ready=0, alu_valid=0, all alu_* outputs 0.
2. **Preload and issue:**
   - Stimulus: wb writes R1=5 and R2=3; then issue SUB rd=3, ra=1, rb=2, upd=1.
   - Required response: next cycle alu_a=5, alu_b=3, alu_opcode=0111, alu_update=1, busy[3]=1.
3. **Back-pressure:**
   - Stimulus: hold alu_ready=0 for 3 cycles with a second word pending.
   - Required response: alu_* outputs stable, in_ready=0; the second word issues the cycle after alu_ready rises.
4. **RAW hazard:**
   - Stimulus: issue ADD rd=4; then AND ra=4, rb=1; writeback R4=8'hAA two cycles later.
   - With ISSUE_FWD_EN: AND accepted in the writeback cycle, alu_a=8'hAA.
   - Without ISSUE_FWD_EN: AND accepted one cycle later, still with alu_a=8'hAA.
5. **R0 and WAW:**
   - Stimulus: writeback to R0 with 8'hFF, then read R0 as a source.
   - Required response: the read returns 0.
   - Stimulus: second issue targeting a busy rd.
   - Required response: stalls until that rd's writeback.
6. **Reset mid-flight:**
   - Stimulus: assert reset with alu_valid=1 and busy[3]=1.
   - Required response: next cycle alu_valid=0, busy cleared; an instruction reading R3 issues immediately after reset.
